// File: rtl/mips_pkg.sv
// Shared definitions for the multi-cycle MIPS control unit.
// Build option: MC_CONTROLLER_MDU_EN enables mult/div/mfhi/mflo and the MDU wait state.
package mips_pkg;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_LUI   = 6'h0F;
   localparam logic [5:0] OP_JAL   = 6'h03;

   localparam logic [5:0] FN_ADD  = 6'h20;
   localparam logic [5:0] FN_SUB  = 6'h22;
   localparam logic [5:0] FN_JR   = 6'h08;
   localparam logic [5:0] FN_MULT = 6'h18;
   localparam logic [5:0] FN_DIV  = 6'h1A;
   localparam logic [5:0] FN_MFHI = 6'h10;
   localparam logic [5:0] FN_MFLO = 6'h12;

   typedef enum logic [2:0] {
      FETCH    = 3'd0,
      DECODE   = 3'd1,
      EXEC     = 3'd2,
      MEM      = 3'd3,
      WB       = 3'd4,
      MDU_WAIT = 3'd5
   } state_t;

   localparam int unsigned ALU_ADD = 0;
   localparam int unsigned ALU_SUB = 1;
   localparam int unsigned ALU_OR  = 2;
   localparam int unsigned ALU_LUI = 3;

   localparam logic [1:0] HILO_NONE = 2'd0;
   localparam logic [1:0] HILO_HI   = 2'd1;
   localparam logic [1:0] HILO_LO   = 2'd2;

   // One bit per instruction class; at most one bit is set for a legal instruction.
   typedef struct packed {
      logic is_add;
      logic is_sub;
      logic is_ori;
      logic is_lw;
      logic is_sw;
      logic is_beq;
      logic is_lui;
      logic is_jal;
      logic is_jr;
      logic is_mult;
      logic is_div;
      logic is_mfhi;
      logic is_mflo;
   } instr_class_t;

endpackage

// File: rtl/mc_controller_if.sv
// Control bus between the instruction register / datapath and mc_controller.
// Build option: MC_CONTROLLER_MDU_EN (only affects what the controller drives).
interface mc_controller_if #(parameter int ALU_CTR_W = 4);

   logic [5:0]           Op;
   logic [5:0]           Funct;
   logic                 Zero;
   logic                 Mem_Ready;

   logic                 PC_Write;
   logic                 IR_Write;
   logic                 Reg_Write;
   logic                 Mem_Write;
   logic                 ALU_Sel;
   logic                 Mem_To_Reg;
   logic                 Reg_Dst;
   logic                 Ext_Op;
   logic                 Jal_Sel;
   logic                 Jr_Sel;
   logic                 Branch;
   logic [ALU_CTR_W-1:0] ALU_Ctr;
   logic                 MDU_Start;
   logic [1:0]           HiLo_Sel;
   logic                 Busy;
   logic                 Illegal;
   logic [2:0]           State;

   modport master (
      input  Op, Funct, Zero, Mem_Ready,
      output PC_Write, IR_Write, Reg_Write, Mem_Write, ALU_Sel, Mem_To_Reg, Reg_Dst,
             Ext_Op, Jal_Sel, Jr_Sel, Branch, ALU_Ctr, MDU_Start, HiLo_Sel, Busy,
             Illegal, State
   );

   modport slave (
      output Op, Funct, Zero, Mem_Ready,
      input  PC_Write, IR_Write, Reg_Write, Mem_Write, ALU_Sel, Mem_To_Reg, Reg_Dst,
             Ext_Op, Jal_Sel, Jr_Sel, Branch, ALU_Ctr, MDU_Start, HiLo_Sel, Busy,
             Illegal, State
   );

endinterface

// File: rtl/mc_decode.sv
// Combinational Op/Funct to instruction-class decoder for mc_controller.
// Build option: MC_CONTROLLER_MDU_EN makes mult/div/mfhi/mflo decodable.
module mc_decode
   import mips_pkg::*;
(
   input  logic [5:0]   op,
   input  logic [5:0]   funct,
   output instr_class_t cls,
   output logic         illegal
);

   // Map the opcode (and funct for R-type) to exactly one class; anything unmatched is illegal.
   always_comb begin
      cls = '0;
      case (op)
         OP_RTYPE: begin
            case (funct)
               FN_ADD:  cls.is_add  = 1'b1;
               FN_SUB:  cls.is_sub  = 1'b1;
               FN_JR:   cls.is_jr   = 1'b1;
`ifdef MC_CONTROLLER_MDU_EN
               FN_MULT: cls.is_mult = 1'b1;
               FN_DIV:  cls.is_div  = 1'b1;
               FN_MFHI: cls.is_mfhi = 1'b1;
               FN_MFLO: cls.is_mflo = 1'b1;
`endif
               default: ;
            endcase
         end
         OP_ORI:  cls.is_ori = 1'b1;
         OP_LW:   cls.is_lw  = 1'b1;
         OP_SW:   cls.is_sw  = 1'b1;
         OP_BEQ:  cls.is_beq = 1'b1;
         OP_LUI:  cls.is_lui = 1'b1;
         OP_JAL:  cls.is_jal = 1'b1;
         default: ;
      endcase
      illegal = (cls == '0);
   end

endmodule

// File: rtl/mc_controller.sv
// Multi-cycle MIPS control unit: FETCH/DECODE/EXEC/MEM/WB sequencer with a
// data-memory ready handshake and an optional multiply/divide wait state.
// Build option: MC_CONTROLLER_MDU_EN enables mult/div/mfhi/mflo, MDU_WAIT and its counter.
module mc_controller
   import mips_pkg::*;
#(
   parameter int ALU_CTR_W = 4,
   parameter int MUL_LAT   = 5,
   parameter int DIV_LAT   = 10
) (
   input  logic            clk,
   input  logic            rst_n,
   mc_controller_if.master bus
);

   if (MUL_LAT < 1 || DIV_LAT < 1) begin : g_lat_check
      $error("mc_controller: MUL_LAT and DIV_LAT must be at least 1");
   end

   instr_class_t cls;
   logic         illegal;
   state_t       state_q;

   mc_decode u_decode (
      .op      (bus.Op),
      .funct   (bus.Funct),
      .cls     (cls),
      .illegal (illegal)
   );

`ifdef MC_CONTROLLER_MDU_EN
   localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
   localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;
   logic [CNT_W-1:0] cnt_q;
`endif

   // Sequence the instruction through the states; the MDU counter rides along with the state.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= FETCH;
`ifdef MC_CONTROLLER_MDU_EN
         cnt_q   <= '0;
`endif
      end else begin
         case (state_q)
            FETCH:  state_q <= DECODE;
            DECODE: state_q <= (illegal || cls.is_jal || cls.is_jr) ? FETCH : EXEC;
            EXEC: begin
               if (cls.is_beq)
                  state_q <= FETCH;
               else if (cls.is_lw || cls.is_sw)
                  state_q <= MEM;
`ifdef MC_CONTROLLER_MDU_EN
               else if (cls.is_mult) begin
                  state_q <= MDU_WAIT;
                  cnt_q   <= CNT_W'(MUL_LAT - 1);
               end else if (cls.is_div) begin
                  state_q <= MDU_WAIT;
                  cnt_q   <= CNT_W'(DIV_LAT - 1);
               end
`else
               else if (cls.is_mult || cls.is_div)
                  state_q <= FETCH;
`endif
               else
                  state_q <= WB;
            end
            MEM: begin
               if (bus.Mem_Ready)
                  state_q <= cls.is_sw ? FETCH : WB;
            end
            WB: state_q <= FETCH;
`ifdef MC_CONTROLLER_MDU_EN
            MDU_WAIT: begin
               if (cnt_q == '0)
                  state_q <= FETCH;
               else
                  cnt_q <= cnt_q - 1'b1;
            end
`endif
            default: state_q <= FETCH;
         endcase
      end
   end

   // Drive the per-cycle enables and selects from the current state and the decoded instruction.
   always_comb begin
      bus.PC_Write   = 1'b0;
      bus.IR_Write   = 1'b0;
      bus.Reg_Write  = 1'b0;
      bus.Mem_Write  = 1'b0;
      bus.ALU_Sel    = 1'b0;
      bus.Mem_To_Reg = 1'b0;
      bus.Reg_Dst    = 1'b0;
      bus.Ext_Op     = 1'b0;
      bus.Jal_Sel    = 1'b0;
      bus.Jr_Sel     = 1'b0;
      bus.Branch     = 1'b0;
      bus.ALU_Ctr    = ALU_CTR_W'(ALU_ADD);
      bus.MDU_Start  = 1'b0;
      bus.HiLo_Sel   = HILO_NONE;
      bus.Busy       = 1'b0;
      bus.Illegal    = 1'b0;
      bus.State      = rst_n ? state_q : FETCH;
      if (rst_n) begin
         case (state_q)
            FETCH: begin
               bus.IR_Write = 1'b1;
               bus.PC_Write = 1'b1;
            end
            DECODE: begin
               if (illegal) begin
                  bus.Illegal = 1'b1;
               end else if (cls.is_jal) begin
                  bus.Reg_Write = 1'b1;
                  bus.Jal_Sel   = 1'b1;
                  bus.PC_Write  = 1'b1;
               end else if (cls.is_jr) begin
                  bus.Jr_Sel   = 1'b1;
                  bus.PC_Write = 1'b1;
               end
            end
            EXEC: begin
               bus.ALU_Sel = cls.is_ori || cls.is_lui || cls.is_lw || cls.is_sw;
               bus.Ext_Op  = cls.is_lw || cls.is_sw || cls.is_beq;
               if (cls.is_sub || cls.is_beq)
                  bus.ALU_Ctr = ALU_CTR_W'(ALU_SUB);
               else if (cls.is_ori)
                  bus.ALU_Ctr = ALU_CTR_W'(ALU_OR);
               else if (cls.is_lui)
                  bus.ALU_Ctr = ALU_CTR_W'(ALU_LUI);
               if (cls.is_beq) begin
                  bus.Branch   = 1'b1;
                  bus.PC_Write = bus.Zero;
               end
`ifdef MC_CONTROLLER_MDU_EN
               bus.MDU_Start = cls.is_mult || cls.is_div;
`endif
            end
            MEM: begin
               bus.Mem_Write = cls.is_sw;
               bus.Busy      = !bus.Mem_Ready;
            end
            WB: begin
               bus.Reg_Write  = 1'b1;
               bus.Mem_To_Reg = cls.is_lw;
               bus.Reg_Dst    = cls.is_add || cls.is_sub || cls.is_mfhi || cls.is_mflo;
`ifdef MC_CONTROLLER_MDU_EN
               if (cls.is_mfhi)
                  bus.HiLo_Sel = HILO_HI;
               else if (cls.is_mflo)
                  bus.HiLo_Sel = HILO_LO;
`endif
            end
`ifdef MC_CONTROLLER_MDU_EN
            MDU_WAIT: bus.Busy = 1'b1;
`endif
            default: ;
         endcase
      end
   end

endmodule
